// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port between NR masters.
// An in-order ID FIFO routes each slave response back to the master that issued it.
module tcdm_rr_arbiter #(
    parameter int unsigned NR      = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NR-1:0]        m_req_i,
    input  logic [NR*AW-1:0]     m_add_i,
    input  logic [NR-1:0]        m_wen_i,
    input  logic [NR*DW/8-1:0]   m_be_i,
    input  logic [NR*DW-1:0]     m_data_i,
    output logic [NR-1:0]        m_gnt_o,
    output logic [DW-1:0]        m_r_data_o,
    output logic [NR-1:0]        m_r_valid_o,
    output logic                 s_req_o,
    output logic [AW-1:0]        s_add_o,
    output logic                 s_wen_o,
    output logic [DW/8-1:0]      s_be_o,
    output logic [DW-1:0]        s_data_o,
    input  logic                 s_gnt_i,
    input  logic [DW-1:0]        s_r_data_i,
    input  logic                 s_r_valid_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned FW = $clog2(MAX_OUT);
    localparam int unsigned CW = FW + 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_fifo [MAX_OUT];
    logic [FW-1:0] r_wptr;
    logic [FW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic [2*NR-1:0] w_req2;
    logic [NR-1:0]   w_rot;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_ptr_nxt;
    logic [IW-1:0]   w_head;
    logic            w_any;
    logic            w_full;
    logic            w_empty;
    logic            w_acc;
    logic            w_pop;

    assign w_any   = |m_req_i;
    assign w_full  = (r_cnt == CW'(MAX_OUT));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rptr];

    // Rotate requests so the pointer position is bit 0, pick the lowest set bit, then un-rotate.
    always_comb begin
        w_req2 = {m_req_i, m_req_i} >> r_ptr;
        w_rot  = w_req2[NR-1:0];
        w_off  = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IW'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IW+1)'(NR)) w_sum = w_sum - (IW+1)'(NR);
        w_win     = w_sum[IW-1:0];
        w_ptr_nxt = (w_win == IW'(NR - 1)) ? '0 : w_win + 1'b1;
    end

    // Full FIFO blocks requests even when a pop happens in the same cycle.
    assign s_req_o = w_any & ~w_full;
    assign w_acc   = s_req_o & s_gnt_i;
    assign w_pop   = s_r_valid_i & ~w_empty;

    always_comb begin
        s_add_o     = '0;
        s_wen_o     = 1'b0;
        s_be_o      = '0;
        s_data_o    = '0;
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        for (int i = 0; i < NR; i++) begin
            if (w_any && (w_win == IW'(i))) begin
                s_add_o  = m_add_i[i*AW +: AW];
                s_wen_o  = m_wen_i[i];
                s_be_o   = m_be_i[i*BW +: BW];
                s_data_o = m_data_i[i*DW +: DW];
            end
            m_gnt_o[i]     = w_acc && (w_win == IW'(i));
            m_r_valid_o[i] = w_pop && (w_head == IW'(i));
        end
    end

    assign m_r_data_o = w_pop ? s_r_data_i : '0;
    assign busy_o     = w_any | ~w_empty;
    assign err_o      = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) r_fifo[i] <= '0;
        end else begin
            if (w_acc) begin
                r_fifo[r_wptr] <= w_win;
                r_wptr         <= r_wptr + 1'b1;
                r_ptr          <= w_ptr_nxt;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_acc && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_acc && w_pop) r_cnt <= r_cnt - 1'b1;
            // A response with nothing outstanding is a protocol violation; sticky until reset.
            if (s_r_valid_i && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed bench for tcdm_rr_arbiter (NR=4, MAX_OUT=4) with a simple in-order memory slave.
module tb_tcdm_rr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;
    localparam int unsigned BW = DW / 8;

    logic              clk_i;
    logic              rst_ni;
    logic [NR-1:0]     m_req_i;
    logic [NR*AW-1:0]  m_add_i;
    logic [NR-1:0]     m_wen_i;
    logic [NR*BW-1:0]  m_be_i;
    logic [NR*DW-1:0]  m_data_i;
    logic [NR-1:0]     m_gnt_o;
    logic [DW-1:0]     m_r_data_o;
    logic [NR-1:0]     m_r_valid_o;
    logic              s_req_o;
    logic [AW-1:0]     s_add_o;
    logic              s_wen_o;
    logic [BW-1:0]     s_be_o;
    logic [DW-1:0]     s_data_o;
    logic              s_gnt_i;
    logic [DW-1:0]     s_r_data_i;
    logic              s_r_valid_i;
    logic              busy_o;
    logic              err_o;

    tcdm_rr_arbiter #(.NR(NR), .AW(AW), .DW(DW), .MAX_OUT(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i), .m_be_i(m_be_i),
        .m_data_i(m_data_i), .m_gnt_o(m_gnt_o), .m_r_data_o(m_r_data_o),
        .m_r_valid_o(m_r_valid_o), .s_req_o(s_req_o), .s_add_o(s_add_o),
        .s_wen_o(s_wen_o), .s_be_o(s_be_o), .s_data_o(s_data_o), .s_gnt_i(s_gnt_i),
        .s_r_data_i(s_r_data_i), .s_r_valid_i(s_r_valid_i), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wen;
        logic [31:0] add;
        logic        sgnt;
        logic [1:0]  rv;     // 0: no response, 1: memory returns oldest pending, 2: forced response
        logic [3:0]  gnt;
        logic [3:0]  rvld;
        logic [31:0] rdata;
        logic        sreq;
        logic [31:0] sadd;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mq[$];
    logic [1:0]  rv_mode;
    logic [31:0] tmp;
    int          checks;
    int          failures;

    // In-order memory slave: captures on handshake, answers from its queue when allowed.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
        end else begin
            if (s_r_valid_i && rv_mode == 2'd1 && mq.size() > 0) tmp = mq.pop_front();
            if (s_req_o && s_gnt_i) begin
                tmp = mem.exists(s_add_o) ? mem[s_add_o] : 32'h0;
                if (!s_wen_o) begin
                    for (int b = 0; b < BW; b++)
                        if (s_be_o[b]) tmp[b*8 +: 8] = s_data_o[b*8 +: 8];
                    mem[s_add_o] = tmp;
                    mq.push_back(32'h0);
                end else begin
                    mq.push_back(tmp);
                end
            end
        end
    end

    function automatic vec_t v(input logic [3:0] req, input logic [3:0] wen,
                               input logic [31:0] add, input logic sgnt, input logic [1:0] rv,
                               input logic [3:0] gnt, input logic [3:0] rvld,
                               input logic [31:0] rdata, input logic sreq,
                               input logic [31:0] sadd, input logic busy, input logic err);
        vec_t r;
        r.req = req; r.wen = wen; r.add = add; r.sgnt = sgnt; r.rv = rv;
        r.gnt = gnt; r.rvld = rvld; r.rdata = rdata; r.sreq = sreq;
        r.sadd = sadd; r.busy = busy; r.err = err;
        return r;
    endfunction

    // Master i presents address add + (i<<16); master 0 writes A5A5A5A5 with be 0011.
    task automatic drive(input logic [3:0] req, input logic [3:0] wen, input logic [31:0] add,
                         input logic sgnt, input logic [1:0] rv);
        m_req_i = req;
        m_wen_i = wen;
        for (int i = 0; i < NR; i++) begin
            m_add_i[i*AW +: AW]  = add + (32'(i) << 16);
            m_be_i[i*BW +: BW]   = (i == 0) ? 4'b0011 : 4'b1111;
            m_data_i[i*DW +: DW] = (i == 0) ? 32'hA5A5A5A5 : 32'(i) * 32'h1111_1111;
        end
        s_gnt_i     = sgnt;
        rv_mode     = rv;
        s_r_valid_i = (rv == 2'd1 && mq.size() > 0) || rv == 2'd2;
        if (rv == 2'd2)       s_r_data_i = 32'hBAD0BAD0;
        else if (s_r_valid_i) s_r_data_i = mq[0];
        else                  s_r_data_i = 32'h0;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t t);
        @(negedge clk_i);
        drive(t.req, t.wen, t.add, t.sgnt, t.rv);
        #1;
        chk("gnt", n, 32'(m_gnt_o), 32'(t.gnt));
        chk("r_valid", n, 32'(m_r_valid_o), 32'(t.rvld));
        if (t.rvld != 4'h0) chk("r_data", n, m_r_data_o, t.rdata);
        chk("s_req", n, 32'(s_req_o), 32'(t.sreq));
        if (t.sreq || t.req == 4'h0) chk("s_add", n, s_add_o, t.sadd);
        chk("busy", n, 32'(busy_o), 32'(t.busy));
        chk("err", n, 32'(err_o), 32'(t.err));
    endtask

    initial begin
        localparam logic [3:0] F = 4'hF;
        localparam logic [3:0] Z = 4'h0;
        checks   = 0;
        failures = 0;
        mem[32'h00110004] = 32'hDEADBEEF;
        for (int i = 0; i < NR; i++) mem[32'(i) << 16] = 32'hC0DE0000 + 32'(i);

        rst_ni = 1'b0;
        drive(Z, F, 32'h0, 1'b0, 2'd0);
        #1;
        chk("rst_gnt", 0, 32'(m_gnt_o), 32'h0);
        chk("rst_sreq", 0, 32'(s_req_o), 32'h0);
        chk("rst_busy", 0, 32'(busy_o), 32'h0);
        chk("rst_err", 0, 32'(err_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // idle
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z, Z, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        // round-robin with 1-cycle response memory
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h1, Z,    32'h0,       1'b1, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h2, 4'h1, 32'hC0DE0000, 1'b1, 32'h00010000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h4, 4'h2, 32'hC0DE0001, 1'b1, 32'h00020000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h8, 4'h4, 32'hC0DE0002, 1'b1, 32'h00030000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h1, 4'h8, 32'hC0DE0003, 1'b1, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h2, 4'h1, 32'hC0DE0000, 1'b1, 32'h00010000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h4, 4'h2, 32'hC0DE0001, 1'b1, 32'h00020000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, 4'h8, 4'h4, 32'hC0DE0002, 1'b1, 32'h00030000, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z,    4'h8, 32'hC0DE0003, 1'b0, 32'h0,        1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z,    Z,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
        // single master 1 read, pointer then sits at 2 and does not move without a handshake
        tbl.push_back(v(4'h2, F, 32'h00100004, 1'b1, 2'd0, 4'h2, Z, 32'h0, 1'b1, 32'h00110004, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h2, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b0, 2'd0, Z, Z, 32'h0, 1'b1, 32'h00020000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b0, 2'd0, Z, Z, 32'h0, 1'b1, 32'h00020000, 1'b1, 1'b0));
        // backpressure: four grants fill the FIFO, pop does not bypass
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h4, Z, 32'h0, 1'b1, 32'h00020000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h8, Z, 32'h0, 1'b1, 32'h00030000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h1, Z, 32'h0, 1'b1, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h2, Z, 32'h0, 1'b1, 32'h00010000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, Z,    Z,    32'h0,        1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd1, Z,    4'h4, 32'hC0DE0002, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h4, Z, 32'h0, 1'b1, 32'h00020000, 1'b1, 1'b0));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, Z,    Z, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h8, 32'hC0DE0003, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h1, 32'hC0DE0000, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h2, 32'hC0DE0001, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h4, 32'hC0DE0002, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z, Z,    32'h0,        1'b0, 32'h0, 1'b0, 1'b0));
        // master 0 partial write, master 1 reads same word; write response only to master 0
        tbl.push_back(v(4'h1, 4'hE, 32'h00200000, 1'b1, 2'd0, 4'h1, Z, 32'h0, 1'b1, 32'h00200000, 1'b1, 1'b0));
        tbl.push_back(v(4'h2, F, 32'h001F0000, 1'b1, 2'd1, 4'h2, 4'h1, 32'h0, 1'b1, 32'h00200000, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h2, 32'h0000A5A5, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z, Z,    32'h0,        1'b0, 32'h0, 1'b0, 1'b0));
        // grant and response for the same master in one cycle
        tbl.push_back(v(4'h1, F, 32'h00200000, 1'b1, 2'd0, 4'h1, Z, 32'h0, 1'b1, 32'h00200000, 1'b1, 1'b0));
        tbl.push_back(v(4'h1, F, 32'h00300000, 1'b1, 2'd1, 4'h1, 4'h1, 32'h0000A5A5, 1'b1, 32'h00300000, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd1, Z, 4'h1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z, Z,    32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        // spurious response sets sticky err
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd2, Z, Z, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z, Z, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(v(Z, F, 32'h0, 1'b1, 2'd0, Z, Z, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        // three outstanding before a mid-flight reset
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h2, Z, 32'h0, 1'b1, 32'h00010000, 1'b1, 1'b1));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h4, Z, 32'h0, 1'b1, 32'h00020000, 1'b1, 1'b1));
        tbl.push_back(v(F, F, 32'h0, 1'b1, 2'd0, 4'h8, Z, 32'h0, 1'b1, 32'h00030000, 1'b1, 1'b1));

        for (int n = 0; n < tbl.size(); n++) run_vec(n, tbl[n]);

        // mid-flight reset: everything clears asynchronously
        @(negedge clk_i);
        drive(Z, F, 32'h0, 1'b1, 2'd0);
        rst_ni = 1'b0;
        #1;
        chk("mrst_gnt", 0, 32'(m_gnt_o), 32'h0);
        chk("mrst_rvld", 0, 32'(m_r_valid_o), 32'h0);
        chk("mrst_rdata", 0, m_r_data_o, 32'h0);
        chk("mrst_sreq", 0, 32'(s_req_o), 32'h0);
        chk("mrst_sadd", 0, s_add_o, 32'h0);
        chk("mrst_busy", 0, 32'(busy_o), 32'h0);
        chk("mrst_err", 0, 32'(err_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(F, F, 32'h0, 1'b1, 2'd0);
        #1;
        chk("post_gnt", 0, 32'(m_gnt_o), 32'h1);
        chk("post_sreq", 0, 32'(s_req_o), 32'h1);
        chk("post_err", 0, 32'(err_o), 32'h0);
        @(negedge clk_i);
        drive(Z, F, 32'h0, 1'b1, 2'd1);
        #1;
        chk("post_rvld", 0, 32'(m_r_valid_o), 32'h1);
        chk("post_rdata", 0, m_r_data_o, 32'hC0DE0000);
        @(negedge clk_i);
        drive(Z, F, 32'h0, 1'b1, 2'd0);
        #1;
        chk("post_busy", 0, 32'(busy_o), 32'h0);
        chk("post_err", 1, 32'(err_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
